// File: rtl/lb_interval_timer.sv
// -----------------------------------------------------------------------------
// lb_interval_timer
//
// Programmable interval timer wrapped around a chain of 4-bit up/down counter
// slices. It captures the period, direction and mode at start, steps the count
// once per SP tick, detects the terminal count, then either reloads
// (auto-reload) or stops in DONE (one-shot). It emits a one-cycle terminal
// pulse and reports BUSY/DONE status.
//
// Parameters:
//   WIDTH  counter width in bits; a multiple of 4 in 4..32 (WIDTH/4 slices)
//   GSR    "ENABLED" or "DISABLED"; selects whether the device global
//          set/reset net also clears the block. The global nets live outside
//          this block, so inside it CD is the only clear source.
//
// Ports:
//   CK     in   clock; all state updates on the rising edge
//   CD     in   asynchronous active-high clear
//   START  in   start/restart request (ignored while running)
//   STOP   in   abort request; has priority over START
//   MODE   in   0 = one-shot, 1 = auto-reload (captured at start)
//   DIR    in   1 = count up, 0 = count down (captured at start)
//   SP     in   count-enable tick; one step per edge with SP=1
//   D      in   period value (captured at start)
//   Q      out  current count, registered
//   CO     out  terminal-count pulse, registered, one CK cycle wide
//   BUSY   out  high while running
//   DONE   out  high after a one-shot period has expired
// -----------------------------------------------------------------------------
module lb_interval_timer #(
  parameter int    WIDTH = 16,
  parameter string GSR   = "ENABLED"
) (
  input  logic             CK,
  input  logic             CD,
  input  logic             START,
  input  logic             STOP,
  input  logic             MODE,
  input  logic             DIR,
  input  logic             SP,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             CO,
  output logic             BUSY,
  output logic             DONE
);

  localparam int SLICES = WIDTH / 4;

  // Elaboration-time guards on the parameter values.
  if ((WIDTH % 4) != 0 || WIDTH < 4 || WIDTH > 32) begin : g_bad_width
    $error("lb_interval_timer: WIDTH must be a multiple of 4 in 4..32");
  end
  if (!(GSR == "ENABLED" || GSR == "DISABLED")) begin : g_bad_gsr
    $error("lb_interval_timer: GSR must be \"ENABLED\" or \"DISABLED\"");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_r, state_n;
  logic [WIDTH-1:0] q_r, q_n;
  logic [WIDTH-1:0] per_r, per_n;
  logic             mode_r, mode_n;
  logic             dir_r, dir_n;
  logic             co_r, co_n;

  // ---------------------------------------------------------------------------
  // Slice chain: WIDTH/4 nibbles, each stepping by its carry/borrow-in, with
  // the carry-in of slice 0 tied high. The final borrow-out of a down count is
  // set only when the whole count is 0, which is the down terminal condition.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] q_step;
  logic             chain_c;
  logic [3:0]       nib;

  always_comb begin
    // NOTE: chain_c and nib are combinational temporaries reused across loop
    // iterations, so blocking assignments are required for the ripple to work.
    chain_c = 1'b1;
    nib     = '0;
    q_step  = '0;
    for (int i = 0; i < SLICES; i++) begin
      nib = q_r[4*i +: 4];
      if (dir_r) begin
        {chain_c, nib} = {1'b0, nib} + 5'(chain_c);
      end else begin
        {chain_c, nib} = {1'b0, nib} - 5'(chain_c);
      end
      q_step[4*i +: 4] = nib;
    end
  end

  // Up counts terminate on the captured period; down counts on chain borrow.
  logic at_term;
  assign at_term = dir_r ? (q_r == per_r) : chain_c;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CK or posedge CD) begin
    if (CD) begin
      state_r <= S_IDLE;
      q_r     <= '0;
      per_r   <= '0;
      mode_r  <= 1'b0;
      dir_r   <= 1'b0;
      co_r    <= 1'b0;
    end else begin
      // NOTE: all registered state uses non-blocking assignments so every
      // register samples the pre-edge values, independent of statement order.
      state_r <= state_n;
      q_r     <= q_n;
      per_r   <= per_n;
      mode_r  <= mode_n;
      dir_r   <= dir_n;
      co_r    <= co_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state / next-count logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would otherwise infer a latch.
    state_n = state_r;
    q_n     = q_r;
    per_n   = per_r;
    mode_n  = mode_r;
    dir_n   = dir_r;
    co_n    = 1'b0;

    case (state_r)
      S_IDLE, S_DONE: begin
        if (STOP) begin
          state_n = S_IDLE;
        end else if (START) begin
          per_n   = D;
          mode_n  = MODE;
          dir_n   = DIR;
          q_n     = DIR ? '0 : D;
          state_n = S_RUN;
        end
      end

      S_RUN: begin
        if (STOP) begin
          // Abort wins even over a terminal step: no pulse, count frozen.
          state_n = S_IDLE;
        end else if (SP) begin
          if (at_term) begin
            co_n = 1'b1;
            if (mode_r) begin
              q_n = dir_r ? '0 : per_r;
            end else begin
              state_n = S_DONE;
            end
          end else begin
            q_n = q_step;
          end
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  assign Q    = q_r;
  assign CO   = co_r;
  assign BUSY = (state_r == S_RUN);
  assign DONE = (state_r == S_DONE);

endmodule

// File: tb/tb_lb_interval_timer.sv
// -----------------------------------------------------------------------------
// tb_lb_interval_timer
//
// Directed scenarios followed by a randomized run, all checked against a
// reference model that tracks the timer as "ticks consumed in the current
// period" rather than as a raw counter value.
// -----------------------------------------------------------------------------
module tb_lb_interval_timer;

  localparam int W = 16;

  logic         CK = 1'b0;
  logic         CD;
  logic         START, STOP, MODE, DIR, SP;
  logic [W-1:0] D;
  logic [W-1:0] Q;
  logic         CO, BUSY, DONE;

  int checks = 0;
  int errors = 0;

  lb_interval_timer #(.WIDTH(W), .GSR("ENABLED")) dut (
    .CK(CK), .CD(CD), .START(START), .STOP(STOP), .MODE(MODE), .DIR(DIR),
    .SP(SP), .D(D), .Q(Q), .CO(CO), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CK = ~CK;

  // ---------------------------------------------------------------------------
  // Reference model: a period is PER+1 ticks; phase counts ticks consumed.
  // Up count shows phase, down count shows PER-phase.
  // ---------------------------------------------------------------------------
  bit m_run, m_done, m_mode, m_dir, m_co;
  int m_per, m_phase;

  function automatic void m_reset();
    m_run = 0; m_done = 0; m_mode = 0; m_dir = 0; m_co = 0;
    m_per = 0; m_phase = 0;
  endfunction

  function automatic logic [W-1:0] m_q();
    return m_dir ? W'(m_phase) : W'(m_per - m_phase);
  endfunction

  function automatic void m_edge(bit start, bit stop, bit mode, bit dir,
                                 bit sp, logic [W-1:0] d);
    m_co = 0;
    if (m_run) begin
      if (stop) begin
        m_run = 0;
      end else if (sp) begin
        if (m_phase == m_per) begin
          m_co = 1;
          if (m_mode) m_phase = 0;
          else begin
            m_run  = 0;
            m_done = 1;
          end
        end else begin
          m_phase++;
        end
      end
    end else if (stop) begin
      m_done = 0;
    end else if (start) begin
      m_per = int'(d); m_mode = mode; m_dir = dir;
      m_phase = 0; m_run = 1; m_done = 0;
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_q"},    32'(Q),    32'(m_q()));
    check({tag, "_co"},   32'(CO),   32'(m_co));
    check({tag, "_busy"}, 32'(BUSY), 32'(m_run));
    check({tag, "_done"}, 32'(DONE), 32'(m_done));
  endtask

  // Drive one cycle of inputs, advance the model, sample #1 after the edge.
  task automatic step(input bit start, input bit stop, input bit mode,
                      input bit dir, input bit sp, input logic [W-1:0] d,
                      input string tag);
    START = start; STOP = stop; MODE = mode; DIR = dir; SP = sp; D = d;
    m_edge(start, stop, mode, dir, sp, d);
    @(posedge CK);
    #1;
    compare_all(tag);
  endtask

  task automatic idle(input string tag);
    step(0, 0, 0, 0, 0, '0, tag);
  endtask

  initial begin
    int co_seen;

    // ---- reset state ------------------------------------------------------
    CD = 1'b1; START = 0; STOP = 0; MODE = 0; DIR = 0; SP = 0; D = '0;
    m_reset();
    #12;
    check("rst_q",    32'(Q),    32'h0);
    check("rst_co",   32'(CO),   32'h0);
    check("rst_busy", 32'(BUSY), 32'h0);
    check("rst_done", 32'(DONE), 32'h0);
    CD = 1'b0;
    idle("rel_idle");

    // ---- asynchronous clear mid-RUN ----------------------------------------
    step(1, 0, 1, 0, 0, 16'h0005, "t1_load");
    repeat (3) step(0, 0, 1, 0, 1, 16'h0005, "t1_tick");
    check("t1_pre_q", 32'(Q), 32'h2);
    #2 CD = 1'b1;
    #1;
    m_reset();
    check("t1_clr_q",    32'(Q),    32'h0);
    check("t1_clr_busy", 32'(BUSY), 32'h0);
    check("t1_clr_co",   32'(CO),   32'h0);
    #2 CD = 1'b0;
    step(0, 0, 1, 0, 1, 16'h0005, "t1_post");
    step(0, 0, 1, 0, 1, 16'h0005, "t1_post");
    check("t1_post_q", 32'(Q), 32'h0);

    // ---- down, one-shot, D=3 -----------------------------------------------
    step(1, 0, 0, 0, 1, 16'd3, "t2_load");
    check("t2_load_q", 32'(Q), 32'd3);
    repeat (4) step(0, 0, 0, 0, 1, 16'd3, "t2_tick");
    check("t2_term_co",   32'(CO),   32'h1);
    check("t2_term_done", 32'(DONE), 32'h1);
    check("t2_term_busy", 32'(BUSY), 32'h0);
    check("t2_term_q",    32'(Q),    32'h0);
    repeat (2) step(0, 0, 0, 0, 1, 16'd3, "t2_hold");
    check("t2_hold_co", 32'(CO), 32'h0);
    step(1, 0, 0, 0, 1, 16'd3, "t2_restart");
    check("t2_restart_q", 32'(Q), 32'd3);
    step(0, 1, 0, 0, 0, '0, "t2_stop");

    // ---- up, auto-reload, D=2, SP toggling ---------------------------------
    step(1, 0, 1, 1, 0, 16'd2, "t3_load");
    co_seen = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 1, 1, (i % 2) == 0, 16'd2, "t3_run");
      if (CO) co_seen++;
    end
    check("t3_co_count", 32'(co_seen), 32'd2);
    check("t3_busy",     32'(BUSY),    32'h1);
    step(0, 1, 0, 0, 0, '0, "t3_stop");

    // ---- down, auto-reload: STOP on a terminal step ------------------------
    step(1, 0, 1, 0, 0, 16'd2, "t4_load");
    repeat (2) step(0, 0, 1, 0, 1, 16'd2, "t4_tick");
    step(0, 1, 1, 0, 1, 16'd2, "t4_stop");
    check("t4_stop_co",   32'(CO),   32'h0);
    check("t4_stop_busy", 32'(BUSY), 32'h0);
    check("t4_stop_q",    32'(Q),    32'h0);

    // ---- down, auto-reload, D=0 --------------------------------------------
    step(1, 0, 1, 0, 1, 16'd0, "t5_load");
    co_seen = 0;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 0, 1, 16'd0, "t5_run");
      if (CO) co_seen++;
    end
    check("t5_co_count", 32'(co_seen), 32'd5);
    step(0, 1, 0, 0, 0, '0, "t5_stop");

    // ---- START+STOP in IDLE, then DIR change mid-RUN -----------------------
    step(1, 1, 0, 1, 1, 16'd9, "t6_both");
    check("t6_both_busy", 32'(BUSY), 32'h0);
    step(1, 0, 0, 1, 0, 16'd4, "t6_load");
    repeat (5) step(0, 0, 1, 0, 1, 16'd7, "t6_run");
    check("t6_end_q",    32'(Q),    32'd4);
    check("t6_end_done", 32'(DONE), 32'h1);
    step(0, 1, 0, 0, 0, '0, "t6_stop");

    // ---- randomized run ----------------------------------------------------
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] d;
      d = ($urandom % 8 == 0) ? W'($urandom) : W'($urandom % 6);
      step(($urandom % 6) == 0, ($urandom % 23) == 0, 1'($urandom),
           1'($urandom), ($urandom % 4) != 0, d, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
